// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver and its companion blocks.
package uart_pkg;

    typedef enum logic [6:0] {
        ST_IDLE   = 7'b0000001,
        ST_START  = 7'b0000010,
        ST_DATA   = 7'b0000100,
        ST_PARITY = 7'b0001000,
        ST_STOP   = 7'b0010000,
        ST_EMIT   = 7'b0100000,
        ST_BREAK  = 7'b1000000
    } state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Smallest width w with 2**w >= value (value of 1 gives 0).
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for an idle-high asynchronous line; resets to the idle level.
module uart_sync_2ff (
    input  logic i_CLK,
    input  logic i_RST_N,
    input  logic i_ASYNC,
    output logic o_SYNC
);

    logic meta_q;
    logic sync_q;
    logic meta_d;
    logic sync_d;

    // Next values: plain shift toward the synchronised output.
    always_comb begin
        meta_d = i_ASYNC;
        sync_d = meta_q;
    end

    // Synchroniser flops; reset to 1 so a reset never looks like a start edge.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_SYNC = sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable data width, parity, stop bits,
// with error flags, false-start rejection and break recovery.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 434,
    parameter int DATA_BITS      = 8,
    parameter int PARITY_MODE    = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic                 i_CLK,
    input  logic                 i_RST_N,
    input  logic                 i_SERIAL_DATA,
    output logic [DATA_BITS-1:0] o_DATA,
    output logic                 o_VALID,
    output logic                 o_PARITY_ERR,
    output logic                 o_FRAME_ERR,
    output logic                 o_BUSY
);

    localparam int CNT_W = clog2(CYCLES_PER_BIT);
    localparam int HALF  = CYCLES_PER_BIT / 2;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [3:0]       IDX_LAST  = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic             ODD_SEL   = (PARITY_MODE == PARITY_ODD);

    logic rx_s;
    logic tick_s;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 out_perr_q, out_perr_d;
    logic                 out_ferr_q, out_ferr_d;
    logic                 busy_q, busy_d;

    uart_sync_2ff u_sync (
        .i_CLK   (i_CLK),
        .i_RST_N (i_RST_N),
        .i_ASYNC (i_SERIAL_DATA),
        .o_SYNC  (rx_s)
    );

    assign tick_s = (cnt_q == CNT_LAST);

    // State and datapath registers.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= 4'd0;
            stop_q     <= 1'b0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            out_perr_q <= 1'b0;
            out_ferr_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stop_q     <= stop_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            out_perr_q <= out_perr_d;
            out_ferr_q <= out_ferr_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = rx_s ? ST_IDLE : ST_START;
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s && (idx_q == IDX_LAST)) begin
                    state_d = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: state_d = tick_s ? ST_STOP : ST_PARITY;
            ST_STOP: begin
                if (tick_s && (stop_q == STOP_LAST)) begin
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_EMIT:   state_d = ferr_q ? ST_BREAK : ST_IDLE;
            ST_BREAK:  state_d = rx_s ? ST_IDLE : ST_BREAK;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Counters, sampling and output-register updates.
    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        stop_d     = stop_q;
        shift_d    = shift_q;
        par_d      = par_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        out_perr_d = out_perr_q;
        out_ferr_d = out_ferr_q;
        busy_d     = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                idx_d  = 4'd0;
                stop_d = 1'b0;
                par_d  = 1'b0;
                perr_d = 1'b0;
                ferr_d = 1'b0;
            end
            ST_START: begin
                cnt_d = (cnt_q == HALF_LAST) ? '0 : cnt_q + CNT_W'(1);
            end
            ST_DATA: begin
                cnt_d = tick_s ? '0 : cnt_q + CNT_W'(1);
                if (tick_s) begin
                    // Shifting right leaves the first wire bit in the LSB.
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    par_d   = par_q ^ rx_s;
                    idx_d   = (idx_q == IDX_LAST) ? idx_q : idx_q + 4'd1;
                end else begin
                    shift_d = shift_q;
                end
            end
            ST_PARITY: begin
                cnt_d = tick_s ? '0 : cnt_q + CNT_W'(1);
                if (tick_s) begin
                    perr_d = ((par_q ^ rx_s) != ODD_SEL);
                end else begin
                    perr_d = perr_q;
                end
            end
            ST_STOP: begin
                cnt_d = tick_s ? '0 : cnt_q + CNT_W'(1);
                if (tick_s) begin
                    ferr_d = ferr_q | ~rx_s;
                    stop_d = stop_q + 1'b1;
                    if (stop_q == STOP_LAST) begin
                        data_d     = shift_q;
                        valid_d    = 1'b1;
                        out_perr_d = perr_q;
                        out_ferr_d = ferr_q | ~rx_s;
                    end else begin
                        valid_d = 1'b0;
                    end
                end else begin
                    ferr_d = ferr_q;
                end
            end
            ST_EMIT:  cnt_d = '0;
            ST_BREAK: cnt_d = '0;
            default:  cnt_d = '0;
        endcase
    end

    assign o_DATA       = data_q;
    assign o_VALID      = valid_q;
    assign o_PARITY_ERR = out_perr_q;
    assign o_FRAME_ERR  = out_ferr_q;
    assign o_BUSY       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed scoreboard bench for uart_rx_cfg: 8N1, 8E1 and 8N2 instances share clock and reset.
module tb_uart_rx_cfg;

    localparam int CPB = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] line = 3'b111;
    logic [7:0] dat [3];
    logic [2:0] vld;
    logic [2:0] pe;
    logic [2:0] fe;
    logic [2:0] bsy;

    exp_t       exp_q [3][$];
    logic [2:0] prev_vld = 3'b000;
    logic [2:0] last_fe  = 3'b000;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CYCLES_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_n1 (
        .i_CLK(clk), .i_RST_N(rst_n), .i_SERIAL_DATA(line[0]), .o_DATA(dat[0]),
        .o_VALID(vld[0]), .o_PARITY_ERR(pe[0]), .o_FRAME_ERR(fe[0]), .o_BUSY(bsy[0]));

    uart_rx_cfg #(.CYCLES_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut_e1 (
        .i_CLK(clk), .i_RST_N(rst_n), .i_SERIAL_DATA(line[1]), .o_DATA(dat[1]),
        .o_VALID(vld[1]), .o_PARITY_ERR(pe[1]), .o_FRAME_ERR(fe[1]), .o_BUSY(bsy[1]));

    uart_rx_cfg #(.CYCLES_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) dut_n2 (
        .i_CLK(clk), .i_RST_N(rst_n), .i_SERIAL_DATA(line[2]), .o_DATA(dat[2]),
        .o_VALID(vld[2]), .o_PARITY_ERR(pe[2]), .o_FRAME_ERR(fe[2]), .o_BUSY(bsy[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int s, input logic [7:0] d, input logic p, input logic f);
        exp_t e;
        e.d = d;
        e.pe = p;
        e.fe = f;
        exp_q[s].push_back(e);
    endtask

    task automatic put_bit(input int s, input logic v);
        line[s] = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input logic [7:0] d, input logic has_par, input logic par_bit,
                        input logic [1:0] stops, input int nstop);
        put_bit(s, 1'b0);
        for (int i = 0; i < 8; i++) put_bit(s, d[i]);
        if (has_par) put_bit(s, par_bit);
        for (int i = 0; i < nstop; i++) put_bit(s, stops[i]);
    endtask

    task automatic check_all_zero(input string tag);
        for (int s = 0; s < 3; s++) begin
            check({tag, "_data"}, 32'(dat[s]), 32'h0);
            check({tag, "_valid"}, 32'(vld[s]), 32'h0);
            check({tag, "_perr"}, 32'(pe[s]), 32'h0);
            check({tag, "_ferr"}, 32'(fe[s]), 32'h0);
            check({tag, "_busy"}, 32'(bsy[s]), 32'h0);
        end
    endtask

    // Output monitor: pops the scoreboard on every valid strobe.
    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (prev_vld[s]) begin
                check("busy_after_emit", 32'(bsy[s]), 32'(last_fe[s]));
            end
            if (vld[s]) begin
                check("valid_not_consecutive", 32'(prev_vld[s]), 32'h0);
                check("valid_expected", 32'(exp_q[s].size() != 0), 32'h1);
                check("busy_in_emit", 32'(bsy[s]), 32'h1);
                if (exp_q[s].size() != 0) begin
                    exp_t e;
                    e = exp_q[s].pop_front();
                    check("data", 32'(dat[s]), 32'(e.d));
                    check("parity_err", 32'(pe[s]), 32'(e.pe));
                    check("frame_err", 32'(fe[s]), 32'(e.fe));
                    last_fe[s] <= e.fe;
                end
            end
        end
        prev_vld <= vld;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        line  = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        put_bit(0, 1'b1);

        // 8N1 single frame.
        push(0, 8'hA5, 1'b0, 1'b0);
        send(0, 8'hA5, 1'b0, 1'b0, 2'b11, 1);
        put_bit(0, 1'b1);

        // Even parity: correct, then wrong parity bit.
        push(1, 8'h37, 1'b0, 1'b0);
        send(1, 8'h37, 1'b1, 1'b1, 2'b11, 1);
        put_bit(1, 1'b1);
        push(1, 8'h37, 1'b1, 1'b0);
        send(1, 8'h37, 1'b1, 1'b0, 2'b11, 1);
        put_bit(1, 1'b1);

        // 8N2 with bad second stop bit followed by a held-low line.
        push(2, 8'h0F, 1'b0, 1'b1);
        send(2, 8'h0F, 1'b0, 1'b0, 2'b01, 2);
        line[2] = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("break_hold_busy", 32'(bsy[2]), 32'h1);
        @(posedge clk);
        #1;
        line[2] = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("break_release_busy", 32'(bsy[2]), 32'h0);
        @(posedge clk);
        #1;

        // Short glitch must be rejected as a false start.
        line[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_set", 32'(bsy[0]), 32'h1);
        @(posedge clk);
        #1;
        line[0] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bsy[0] !== 1'b0 && n < 12);
        check("glitch_busy_clear", 32'(bsy[0]), 32'h0);
        @(posedge clk);
        #1;
        put_bit(0, 1'b1);
        put_bit(0, 1'b1);

        // Back-to-back frames with no idle gap.
        push(0, 8'h00, 1'b0, 1'b0);
        push(0, 8'hFF, 1'b0, 1'b0);
        push(0, 8'h5A, 1'b0, 1'b0);
        send(0, 8'h00, 1'b0, 1'b0, 2'b11, 1);
        send(0, 8'hFF, 1'b0, 1'b0, 2'b11, 1);
        send(0, 8'h5A, 1'b0, 1'b0, 2'b11, 1);
        put_bit(0, 1'b1);

        // Reset during bit 4 of 0xC3 abandons that frame.
        put_bit(0, 1'b0);
        put_bit(0, 1'b1);
        put_bit(0, 1'b1);
        put_bit(0, 1'b0);
        put_bit(0, 1'b0);
        line[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        line  = 3'b111;
        @(negedge clk);
        check_all_zero("midframe_reset");
        @(posedge clk);
        #1;
        put_bit(0, 1'b1);
        put_bit(0, 1'b1);
        push(0, 8'h81, 1'b0, 1'b0);
        send(0, 8'h81, 1'b0, 1'b0, 2'b11, 1);
        put_bit(0, 1'b1);
        put_bit(0, 1'b1);

        for (int s = 0; s < 3; s++) begin
            check("scoreboard_drained", 32'(exp_q[s].size()), 32'h0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
